// File: rtl/tournament_chooser_table_pkg.sv
// Shared types and default sizing for the tournament chooser table.
package tournament_chooser_table_pkg;

  localparam int CHOOSER_ENTRIES   = 512;
  localparam int CHOOSER_CTR_WIDTH = 2;
  localparam int CHOOSER_GHR_WIDTH = 9;

  // INIT sweeps every entry to the weakly-gshare value; READY serves traffic.
  typedef enum logic {
    CHOOSER_INIT,
    CHOOSER_READY
  } chooser_state_t;

endpackage

// File: rtl/tournament_chooser_table_sat_ctr.sv
// Combinational saturating next-value for one chooser counter.
// inc and dec together (or neither) leave the counter unchanged.
module tournament_chooser_table_sat_ctr
  import tournament_chooser_table_pkg::*;
#(
  parameter int CTR_WIDTH = CHOOSER_CTR_WIDTH
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CTR_WIDTH-1:0] ctr_nxt
);

  // One extra bit catches the carry out of the top and the borrow below zero.
  function automatic logic [CTR_WIDTH-1:0] sat_inc(input logic [CTR_WIDTH-1:0] v);
    logic [CTR_WIDTH:0] sum;
    sum = {1'b0, v} + {{CTR_WIDTH{1'b0}}, 1'b1};
    return sum[CTR_WIDTH] ? {CTR_WIDTH{1'b1}} : sum[CTR_WIDTH-1:0];
  endfunction

  function automatic logic [CTR_WIDTH-1:0] sat_dec(input logic [CTR_WIDTH-1:0] v);
    logic [CTR_WIDTH:0] diff;
    diff = {1'b0, v} - {{CTR_WIDTH{1'b0}}, 1'b1};
    return diff[CTR_WIDTH] ? {CTR_WIDTH{1'b0}} : diff[CTR_WIDTH-1:0];
  endfunction

  // Select the saturated step in the requested direction.
  always_comb begin
    ctr_nxt = ctr;
    if (inc && !dec)      ctr_nxt = sat_inc(ctr);
    else if (dec && !inc) ctr_nxt = sat_dec(ctr);
  end

endmodule

// File: rtl/tournament_chooser_table.sv
// Tournament chooser: per-branch saturating counters that pick gshare (MSB=1)
// or the 2-level predictor (MSB=0). Trains only on component disagreement and
// sweeps the table to the weakly-gshare value after every reset.
// Optional build macro CHOOSER_GHR_HASH_EN: XOR global history into the lookup index.
module tournament_chooser_table
  import tournament_chooser_table_pkg::*;
#(
  parameter int  NUM_ENTRIES = CHOOSER_ENTRIES,
  parameter int  CTR_WIDTH   = CHOOSER_CTR_WIDTH,
  parameter int  GHR_WIDTH   = CHOOSER_GHR_WIDTH,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_pc,
  input  logic [GHR_WIDTH-1:0] lookup_ghr,
  output logic                 lookup_resp_valid,
  output logic                 lookup_choose_gshare,
  output logic [IDX_W-1:0]     lookup_resp_idx,
  input  logic                 upd_valid,
  input  logic [IDX_W-1:0]     upd_idx,
  input  logic                 upd_local_correct,
  input  logic                 upd_gshare_correct
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             local_correct;
    logic             gshare_correct;
  } chooser_upd_t;

  localparam logic [CTR_WIDTH-1:0] INIT_VAL = {1'b1, {(CTR_WIDTH-1){1'b0}}};
  localparam int                   GHR_KEEP = (GHR_WIDTH < IDX_W) ? GHR_WIDTH : IDX_W;

  chooser_state_t       state;
  logic [IDX_W-1:0]     sweep_ptr;
  logic [CTR_WIDTH-1:0] ctr_table [NUM_ENTRIES];

  chooser_upd_t         upd_p0;
  logic                 lookup_acc_p0;
  logic                 upd_acc_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic [IDX_W-1:0]     ghr_idx_p0;
  logic [CTR_WIDTH-1:0] upd_ctr_p0;
  logic [CTR_WIDTH-1:0] upd_nxt_p0;
  logic [CTR_WIDTH-1:0] lookup_ctr_p0;

  logic                 vld_p1;
  logic                 choose_p1;
  logic [IDX_W-1:0]     idx_p1;

  logic                 unused_inputs;

  assign unused_inputs = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], lookup_ghr};

  // ---- stage p0: accept, index, counter read/next-value, bypass ----
  assign upd_p0        = '{idx: upd_idx, local_correct: upd_local_correct,
                           gshare_correct: upd_gshare_correct};
  assign lookup_acc_p0 = !rst && (state == CHOOSER_READY) && lookup_valid;
  assign upd_acc_p0    = !rst && (state == CHOOSER_READY) && upd_valid;

  // Keep the low history bits, zero-extend when history is narrower than the index.
  always_comb begin
    ghr_idx_p0                 = '0;
    ghr_idx_p0[GHR_KEEP-1:0]   = lookup_ghr[GHR_KEEP-1:0];
  end

`ifdef CHOOSER_GHR_HASH_EN
  assign idx_p0 = lookup_pc[IDX_W+1:2] ^ ghr_idx_p0;
`else
  logic unused_ghr_idx;
  assign unused_ghr_idx = ^ghr_idx_p0;
  assign idx_p0         = lookup_pc[IDX_W+1:2];
`endif

  assign upd_ctr_p0 = ctr_table[upd_p0.idx];

  tournament_chooser_table_sat_ctr #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_sat_ctr (
    .ctr     (upd_ctr_p0),
    .inc     (upd_p0.gshare_correct && !upd_p0.local_correct),
    .dec     (upd_p0.local_correct && !upd_p0.gshare_correct),
    .ctr_nxt (upd_nxt_p0)
  );

  // A same-cycle update to the looked-up entry is forwarded so the response sees it.
  assign lookup_ctr_p0 = (upd_acc_p0 && (upd_p0.idx == idx_p0)) ? upd_nxt_p0
                                                                : ctr_table[idx_p0];

  // Init sweep walks the pointer across the table, then parks in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CHOOSER_INIT;
      sweep_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        CHOOSER_INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == IDX_W'(NUM_ENTRIES - 1)) begin
            state <= CHOOSER_READY;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= CHOOSER_READY;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Counter storage: sweep writes during INIT, training writes once ready.
  always_ff @(posedge clk) begin
    if (state == CHOOSER_INIT)
      ctr_table[sweep_ptr] <= INIT_VAL;
    else if (upd_acc_p0)
      ctr_table[upd_p0.idx] <= upd_nxt_p0;
  end

  // ---- stage p1: registered lookup response ----
  // Response valid pulses one cycle after an accepted lookup; choice and index hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      choose_p1 <= 1'b0;
      idx_p1    <= '0;
    end else begin
      vld_p1 <= lookup_acc_p0;
      if (lookup_acc_p0) begin
        choose_p1 <= lookup_ctr_p0[CTR_WIDTH-1];
        idx_p1    <= idx_p0;
      end
    end
  end

  assign lookup_resp_valid    = vld_p1;
  assign lookup_choose_gshare = choose_p1;
  assign lookup_resp_idx      = idx_p1;

endmodule

// File: tb/tb_tournament_chooser_table.sv
// Directed bench for tournament_chooser_table with an 8-entry, 2-bit, 3-bit-history build.
module tb_tournament_chooser_table;

  localparam int NE = 8;
  localparam int CW = 2;
  localparam int GW = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          lookup_valid;
  logic [31:0]   lookup_pc;
  logic [GW-1:0] lookup_ghr;
  logic          lookup_resp_valid;
  logic          lookup_choose_gshare;
  logic [IW-1:0] lookup_resp_idx;
  logic          upd_valid;
  logic [IW-1:0] upd_idx;
  logic          upd_local_correct;
  logic          upd_gshare_correct;

  int errors = 0;
  int checks = 0;

  tournament_chooser_table #(
    .NUM_ENTRIES (NE),
    .CTR_WIDTH   (CW),
    .GHR_WIDTH   (GW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ready                (ready),
    .lookup_valid         (lookup_valid),
    .lookup_pc            (lookup_pc),
    .lookup_ghr           (lookup_ghr),
    .lookup_resp_valid    (lookup_resp_valid),
    .lookup_choose_gshare (lookup_choose_gshare),
    .lookup_resp_idx      (lookup_resp_idx),
    .upd_valid            (upd_valid),
    .upd_idx              (upd_idx),
    .upd_local_correct    (upd_local_correct),
    .upd_gshare_correct   (upd_gshare_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          lv;
    logic [31:0]   pc;
    logic          uv;
    logic [IW-1:0] ui;
    logic          lc;
    logic          gc;
    logic          rv;
    logic          ch;
    logic [IW-1:0] ix;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic lv, input logic [31:0] pc, input logic uv,
                              input logic [IW-1:0] ui, input logic lc, input logic gc,
                              input logic rv, input logic ch, input logic [IW-1:0] ix);
    vec_t v;
    v.lv = lv; v.pc = pc; v.uv = uv; v.ui = ui; v.lc = lc; v.gc = gc;
    v.rv = rv; v.ch = ch; v.ix = ix;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_valid       = 1'b0;
    lookup_pc          = '0;
    lookup_ghr         = '0;
    upd_valid          = 1'b0;
    upd_idx            = '0;
    upd_local_correct  = 1'b0;
    upd_gshare_correct = 1'b0;
  endtask

  initial begin
    // lv  pc          uv ui lc gc   rv ch ix
    vecs[0]  = mk(1, 32'h14, 0, 0, 0, 0, 1, 1, 5);   // init value 10
    vecs[1]  = mk(0, 32'h00, 1, 5, 1, 0, 0, 1, 5);   // 10->01, outputs hold
    vecs[2]  = mk(1, 32'h14, 0, 0, 0, 0, 1, 0, 5);
    vecs[3]  = mk(0, 32'h00, 1, 5, 1, 0, 0, 0, 5);   // 01->00
    vecs[4]  = mk(1, 32'h14, 1, 5, 1, 0, 1, 0, 5);   // floor holds 00
    vecs[5]  = mk(1, 32'h14, 1, 5, 0, 1, 1, 0, 5);   // 00->01
    vecs[6]  = mk(1, 32'h14, 1, 5, 0, 1, 1, 1, 5);   // 01->10
    vecs[7]  = mk(1, 32'h14, 1, 5, 0, 1, 1, 1, 5);   // 10->11
    vecs[8]  = mk(1, 32'h14, 1, 5, 0, 1, 1, 1, 5);   // ceiling holds 11
    vecs[9]  = mk(1, 32'h14, 1, 5, 1, 0, 1, 1, 5);   // 11->10
    vecs[10] = mk(1, 32'h14, 1, 5, 1, 1, 1, 1, 5);   // agree: stays 10
    vecs[11] = mk(1, 32'h14, 1, 5, 0, 0, 1, 1, 5);   // agree: stays 10
    vecs[12] = mk(1, 32'h14, 1, 5, 1, 0, 1, 0, 5);   // 10->01
    vecs[13] = mk(0, 32'h00, 1, 5, 1, 1, 0, 0, 5);   // agree, no lookup
    vecs[14] = mk(1, 32'h14, 0, 0, 0, 0, 1, 0, 5);   // still 01
    vecs[15] = mk(1, 32'h0C, 1, 3, 1, 0, 1, 0, 3);   // bypass 10->01
    vecs[16] = mk(1, 32'h0C, 0, 0, 0, 0, 1, 0, 3);
    vecs[17] = mk(1, 32'h14, 1, 3, 0, 1, 1, 0, 5);   // other idx trained, 3: 01->10
    vecs[18] = mk(1, 32'h0C, 0, 0, 0, 0, 1, 1, 3);
    vecs[19] = mk(1, 32'h20000017, 0, 0, 0, 0, 1, 0, 5); // upper/low pc bits ignored
    vecs[20] = mk(0, 32'h00, 0, 0, 0, 0, 0, 0, 5);   // idle: hold

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_ready", 32'(ready), 0);
    check("reset_resp_valid", 32'(lookup_resp_valid), 0);
    check("reset_choose", 32'(lookup_choose_gshare), 0);
    check("reset_idx", 32'(lookup_resp_idx), 0);

    // Init sweep with a lookup held high that must be ignored.
    rst          = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("init_ready_c%0d", c), 32'(ready), 0);
      check($sformatf("init_resp_valid_c%0d", c), 32'(lookup_resp_valid), 0);
    end
    tick();
    check("init_ready_c9", 32'(ready), 1);
    check("init_last_resp_valid", 32'(lookup_resp_valid), 0);

    // Table-driven training, bypass and hold vectors.
    for (int i = 0; i < 21; i++) begin
      lookup_valid       = vecs[i].lv;
      lookup_pc          = vecs[i].pc;
      upd_valid          = vecs[i].uv;
      upd_idx            = vecs[i].ui;
      upd_local_correct  = vecs[i].lc;
      upd_gshare_correct = vecs[i].gc;
      tick();
      check($sformatf("v%0d_resp_valid", i), 32'(lookup_resp_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d_choose", i), 32'(lookup_choose_gshare), 32'(vecs[i].ch));
      check($sformatf("v%0d_idx", i), 32'(lookup_resp_idx), 32'(vecs[i].ix));
    end
    idle_inputs();

    // History input: used only by the hash build.
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    lookup_ghr   = 3'b011;
    tick();
`ifdef CHOOSER_GHR_HASH_EN
    check("ghr_hash_idx", 32'(lookup_resp_idx), 6);
`else
    check("ghr_ignored_idx", 32'(lookup_resp_idx), 5);
`endif
    idle_inputs();

    // Reset with a lookup in flight drops the response.
    rst          = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    tick();
    check("rst_drop_resp_valid", 32'(lookup_resp_valid), 0);
    check("rst_ready_low", 32'(ready), 0);
    idle_inputs();
    rst = 1'b0;
    for (int c = 2; c <= 4; c++) tick();

    // Mid-sweep reset restarts the sweep from entry 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("resweep_ready_c%0d", c), 32'(ready), 0);
    end
    tick();
    check("resweep_ready_c9", 32'(ready), 1);

    // Every entry, including previously trained 3 and 5, reads weakly gshare.
    for (int e = 0; e < NE; e++) begin
      lookup_valid = 1'b1;
      lookup_pc    = 32'(e * 4);
      tick();
      check($sformatf("resweep_e%0d_valid", e), 32'(lookup_resp_valid), 1);
      check($sformatf("resweep_e%0d_choose", e), 32'(lookup_choose_gshare), 1);
      check($sformatf("resweep_e%0d_idx", e), 32'(lookup_resp_idx), 32'(e));
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
